// File: rtl/kim_mips_pkg.sv
// Shared MIPS pipeline definitions: register address width, hazard FSM
// encoding, default hazard-controller tuning and the load-use detector.
package kim_mips_pkg;

    localparam int REG_ADDR_W = 5;

    localparam int DEF_LOAD_STALL_CYCLES = 1;
    localparam int DEF_MEM_TIMEOUT       = 255;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_e;

    // A load in EX whose destination feeds a source of the ID instruction;
    // $zero is never a real dependency.
    function automatic logic load_use_hazard(
        input logic                  ex_memtoreg,
        input logic [REG_ADDR_W-1:0] ex_rt,
        input logic [REG_ADDR_W-1:0] id_rs,
        input logic [REG_ADDR_W-1:0] id_rt,
        input logic                  id_uses_rt
    );
        return ex_memtoreg && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/kim_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. master is the pipeline side
// (drives decode/memory status), slave is the hazard controller side.
interface kim_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [kim_mips_pkg::REG_ADDR_W-1:0] id_rs;
    logic [kim_mips_pkg::REG_ADDR_W-1:0] id_rt;
    logic                                id_uses_rt;
    logic                                ex_memtoreg;
    logic [kim_mips_pkg::REG_ADDR_W-1:0] ex_rt;
    logic                                branch_taken;
    logic                                dmem_req;
    logic                                dmem_ready;
    logic                                perf_clr;
    logic                                pc_we;
    logic                                if_id_we;
    logic                                if_id_flush;
    logic                                id_ex_bubble;
    logic                                pipe_hold;
    logic                                mem_err;
    logic [CNT_W-1:0]                    stall_cnt;
    logic [CNT_W-1:0]                    flush_cnt;
    logic [1:0]                          state;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memtoreg, ex_rt,
               branch_taken, dmem_req, dmem_ready, perf_clr,
        input  pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_hold,
               mem_err, stall_cnt, flush_cnt, state
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memtoreg, ex_rt,
               branch_taken, dmem_req, dmem_ready, perf_clr,
        output pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_hold,
               mem_err, stall_cnt, flush_cnt, state
    );
endinterface

// File: rtl/kim_sat_counter.sv
// Up-counter that sticks at all ones; synchronous clear wins over increment.
module kim_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: default assigned first so every path writes count_d and no latch is inferred.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/kim_hazard_ctrl.sv
// MIPS hazard controller: load-use bubbles, data-memory wait with timeout,
// branch flush of IF/ID and saturating stall/flush performance counters.
module kim_hazard_ctrl
    import kim_mips_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = DEF_LOAD_STALL_CYCLES,
    parameter int MEM_TIMEOUT       = DEF_MEM_TIMEOUT,
    parameter int CNT_W             = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_memtoreg,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    input  logic                  perf_clr,
    output logic                  pc_we,
    output logic                  if_id_we,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  pipe_hold,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [1:0]            state
);
    localparam logic [1:0] LU_LOAD      = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    hz_state_e  state_q, state_d;
    logic [1:0] lu_cnt_q, lu_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;
    logic       lu;
    logic       mem_stall;

    assign lu        = load_use_hazard(ex_memtoreg, ex_rt, id_rs, id_rt, id_uses_rt);
    assign mem_stall = dmem_req && !dmem_ready;

    always_comb begin
        state_d      = state_q;
        lu_cnt_d     = lu_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        mem_err_d    = 1'b0;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    pc_we      = 1'b0;
                    if_id_we   = 1'b0;
                    pipe_hold  = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end else if (lu) begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d  = ST_LU_STALL;
                        lu_cnt_d = LU_LOAD;
                    end
                end else if (branch_taken) begin
                    if_id_flush = 1'b1;
                end
            end

            // Decode inputs are stale here; only a memory wait can cut the bubbles short.
            ST_LU_STALL: begin
                pc_we    = 1'b0;
                if_id_we = 1'b0;
                if (mem_stall) begin
                    pipe_hold  = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                    lu_cnt_d   = '0;
                end else begin
                    id_ex_bubble = 1'b1;
                    lu_cnt_d     = lu_cnt_q - 2'd1;
                    if (lu_cnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_MEM_WAIT: begin
                pc_we      = 1'b0;
                if_id_we   = 1'b0;
                pipe_hold  = 1'b1;
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (dmem_ready) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_RUN;
                    mem_err_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Reset parks the pipeline with a bubble in ID/EX regardless of FSM state.
        if (!rstn) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b1;
            pipe_hold    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_RUN;
            lu_cnt_q   <= '0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    kim_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (!pc_we),
        .clr   (perf_clr),
        .count (stall_cnt)
    );

    kim_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (if_id_flush),
        .clr   (perf_clr),
        .count (flush_cnt)
    );

    assign mem_err = mem_err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_kim_hazard_ctrl.sv
// Scoreboard bench for kim_hazard_ctrl: dut_a (1 bubble, long timeout, 16-bit
// counters) and dut_b (3 bubbles, timeout 4, 4-bit counters) on one clock.
module tb_kim_hazard_ctrl;
    import kim_mips_pkg::*;

    localparam int RUN = int'(ST_RUN);
    localparam int LUS = int'(ST_LU_STALL);
    localparam int MW  = int'(ST_MEM_WAIT);

    // Expected control pattern of one cycle.
    typedef enum logic [2:0] {C_N, C_S, C_H, C_F, C_R} ctrl_e;

    typedef struct {
        int         sel;
        ctrl_e      c;
        logic [1:0] st;
        logic       err;
        logic       mtr;
        logic [4:0] ex_rt, rs, rt;
        logic       uses, br, req, rdy, clr, rn;
    } row_t;

    typedef struct packed {
        logic        pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_hold, mem_err;
        logic [1:0]  st;
        logic [15:0] stall, flush;
    } obs_t;

    logic clk;
    logic rstn;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   stall_m[2];
    int   flush_m[2];
    obs_t sb_q[$];

    kim_hazard_ctrl_if #(.CNT_W(16)) if_a ();
    kim_hazard_ctrl_if #(.CNT_W(4))  if_b ();

    kim_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(255), .CNT_W(16)) dut_a (
        .clk(clk), .rstn(rstn),
        .id_rs(if_a.id_rs), .id_rt(if_a.id_rt), .id_uses_rt(if_a.id_uses_rt),
        .ex_memtoreg(if_a.ex_memtoreg), .ex_rt(if_a.ex_rt), .branch_taken(if_a.branch_taken),
        .dmem_req(if_a.dmem_req), .dmem_ready(if_a.dmem_ready), .perf_clr(if_a.perf_clr),
        .pc_we(if_a.pc_we), .if_id_we(if_a.if_id_we), .if_id_flush(if_a.if_id_flush),
        .id_ex_bubble(if_a.id_ex_bubble), .pipe_hold(if_a.pipe_hold), .mem_err(if_a.mem_err),
        .stall_cnt(if_a.stall_cnt), .flush_cnt(if_a.flush_cnt), .state(if_a.state)
    );

    kim_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
        .clk(clk), .rstn(rstn),
        .id_rs(if_b.id_rs), .id_rt(if_b.id_rt), .id_uses_rt(if_b.id_uses_rt),
        .ex_memtoreg(if_b.ex_memtoreg), .ex_rt(if_b.ex_rt), .branch_taken(if_b.branch_taken),
        .dmem_req(if_b.dmem_req), .dmem_ready(if_b.dmem_ready), .perf_clr(if_b.perf_clr),
        .pc_we(if_b.pc_we), .if_id_we(if_b.if_id_we), .if_id_flush(if_b.if_id_flush),
        .id_ex_bubble(if_b.id_ex_bubble), .pipe_hold(if_b.pipe_hold), .mem_err(if_b.mem_err),
        .stall_cnt(if_b.stall_cnt), .flush_cnt(if_b.flush_cnt), .state(if_b.state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Argument order: sel, ctrl, state, mem_err, ex_memtoreg, ex_rt, id_rs, id_rt,
    // id_uses_rt, branch_taken, dmem_req, dmem_ready, perf_clr, rstn.
    function automatic row_t r(int sel, ctrl_e c, int st, int err, int mtr, int ex_rt,
                               int rs, int rt, int uses, int br, int req, int rdy,
                               int clr, int rn);
        row_t w;
        w.sel = sel;          w.c     = c;          w.st   = 2'(st);
        w.err = 1'(err);      w.mtr   = 1'(mtr);    w.ex_rt = 5'(ex_rt);
        w.rs  = 5'(rs);       w.rt    = 5'(rt);     w.uses = 1'(uses);
        w.br  = 1'(br);       w.req   = 1'(req);    w.rdy  = 1'(rdy);
        w.clr = 1'(clr);      w.rn    = 1'(rn);
        return w;
    endfunction

    function automatic row_t idle(int sel, ctrl_e c, int st, int err);
        return r(sel, c, st, err, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endfunction

    function automatic row_t mem(int sel, ctrl_e c, int st, int br, int req, int rdy);
        return r(sel, c, st, 0, 0, 0, 0, 0, 0, br, req, rdy, 0, 1);
    endfunction

    // {pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_hold}
    function automatic logic [4:0] ctrl_bits(ctrl_e c);
        case (c)
            C_N:     return 5'b11000;
            C_F:     return 5'b11100;
            C_H:     return 5'b00001;
            default: return 5'b00010;
        endcase
    endfunction

    function automatic int cnt_max(int sel);
        return (sel == 0) ? 65535 : 15;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("pc_we=%b if_id_we=%b flush=%b bubble=%b hold=%b mem_err=%b state=%0d stall_cnt=%0d flush_cnt=%0d",
                         o.pc_we, o.if_id_we, o.if_id_flush, o.id_ex_bubble, o.pipe_hold,
                         o.mem_err, o.st, o.stall, o.flush);
    endfunction

    function automatic obs_t sample(int sel);
        obs_t o;
        if (sel == 0) begin
            o = {if_a.pc_we, if_a.if_id_we, if_a.if_id_flush, if_a.id_ex_bubble, if_a.pipe_hold,
                 if_a.mem_err, if_a.state, if_a.stall_cnt, if_a.flush_cnt};
        end else begin
            o = {if_b.pc_we, if_b.if_id_we, if_b.if_id_flush, if_b.id_ex_bubble, if_b.pipe_hold,
                 if_b.mem_err, if_b.state, 16'(if_b.stall_cnt), 16'(if_b.flush_cnt)};
        end
        return o;
    endfunction

    // The unselected DUT always sees an idle pipeline.
    task automatic apply(input row_t w);
        rstn = w.rn;
        if_a.id_rs = '0; if_a.id_rt = '0; if_a.id_uses_rt = 1'b0; if_a.ex_memtoreg = 1'b0;
        if_a.ex_rt = '0; if_a.branch_taken = 1'b0; if_a.dmem_req = 1'b0;
        if_a.dmem_ready = 1'b0; if_a.perf_clr = 1'b0;
        if_b.id_rs = '0; if_b.id_rt = '0; if_b.id_uses_rt = 1'b0; if_b.ex_memtoreg = 1'b0;
        if_b.ex_rt = '0; if_b.branch_taken = 1'b0; if_b.dmem_req = 1'b0;
        if_b.dmem_ready = 1'b0; if_b.perf_clr = 1'b0;
        if (w.sel == 0) begin
            if_a.id_rs = w.rs; if_a.id_rt = w.rt; if_a.id_uses_rt = w.uses;
            if_a.ex_memtoreg = w.mtr; if_a.ex_rt = w.ex_rt; if_a.branch_taken = w.br;
            if_a.dmem_req = w.req; if_a.dmem_ready = w.rdy; if_a.perf_clr = w.clr;
        end else begin
            if_b.id_rs = w.rs; if_b.id_rt = w.rt; if_b.id_uses_rt = w.uses;
            if_b.ex_memtoreg = w.mtr; if_b.ex_rt = w.ex_rt; if_b.branch_taken = w.br;
            if_b.dmem_req = w.req; if_b.dmem_ready = w.rdy; if_b.perf_clr = w.clr;
        end
    endtask

    // Drive one cycle, push its prediction, pop it against the negedge sample,
    // then advance the counter model from the predicted controls.
    task automatic cycle(input row_t w, output obs_t got, output obs_t want);
        obs_t e;
        apply(w);
        if (!w.rn) begin
            stall_m[0] = 0; stall_m[1] = 0; flush_m[0] = 0; flush_m[1] = 0;
        end
        {e.pc_we, e.if_id_we, e.if_id_flush, e.id_ex_bubble, e.pipe_hold} = ctrl_bits(w.c);
        e.mem_err = w.err;
        e.st      = w.st;
        e.stall   = 16'(stall_m[w.sel]);
        e.flush   = 16'(flush_m[w.sel]);
        sb_q.push_back(e);
        @(negedge clk);
        got  = sample(w.sel);
        want = sb_q.pop_front();
        if (w.rn) begin
            if (w.clr) begin
                stall_m[w.sel] = 0;
                flush_m[w.sel] = 0;
            end else begin
                if (!want.pc_we && stall_m[w.sel] < cnt_max(w.sel)) stall_m[w.sel]++;
                if (want.if_id_flush && flush_m[w.sel] < cnt_max(w.sel)) flush_m[w.sel]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        obs_t got, want;
        rows.push_back(r(0, C_R, RUN, 0, 1, 8, 8, 0, 0, 1, 1, 0, 0, 0));
        rows.push_back(r(1, C_R, RUN, 0, 1, 8, 8, 0, 0, 1, 1, 0, 0, 0));
        rows.push_back(idle(0, C_N, RUN, 0));
        rows.push_back(idle(1, C_N, RUN, 0));
        foreach (rows[i]) begin
            cycle(rows[i], got, want);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset[%0d] got {%s} want {%s}", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_lu_single();
        row_t rows[$];
        obs_t got, want;
        rows.push_back(r(0, C_S, RUN, 0, 1, 8, 8, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(idle(0, C_N, RUN, 0));
        rows.push_back(idle(0, C_N, RUN, 0));
        foreach (rows[i]) begin
            cycle(rows[i], got, want);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL lu_single[%0d] got {%s} want {%s}", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_no_stall();
        row_t rows[$];
        obs_t got, want;
        rows.push_back(r(0, C_N, RUN, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(r(0, C_N, RUN, 0, 1, 8, 3, 8, 0, 0, 0, 0, 0, 1));
        rows.push_back(r(0, C_S, RUN, 0, 1, 8, 3, 8, 1, 0, 0, 0, 0, 1));
        rows.push_back(r(0, C_N, RUN, 0, 0, 8, 8, 8, 1, 0, 0, 0, 0, 1));
        foreach (rows[i]) begin
            cycle(rows[i], got, want);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL no_stall[%0d] got {%s} want {%s}", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_lu_multi();
        row_t rows[$];
        obs_t got, want;
        rows.push_back(r(1, C_S, RUN, 0, 1, 8, 8, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(r(1, C_S, LUS, 0, 1, 8, 8, 0, 0, 1, 0, 0, 0, 1));
        rows.push_back(r(1, C_S, LUS, 0, 1, 8, 8, 0, 0, 1, 0, 0, 0, 1));
        rows.push_back(idle(1, C_N, RUN, 0));
        rows.push_back(r(1, C_S, RUN, 0, 1, 9, 9, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(mem(1, C_H, LUS, 0, 1, 0));
        rows.push_back(mem(1, C_H, MW, 0, 1, 1));
        rows.push_back(idle(1, C_N, RUN, 0));
        foreach (rows[i]) begin
            cycle(rows[i], got, want);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL lu_multi[%0d] got {%s} want {%s}", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_mem_wait();
        row_t rows[$];
        obs_t got, want;
        rows.push_back(mem(0, C_H, RUN, 0, 1, 0));
        for (int k = 0; k < 4; k++) rows.push_back(mem(0, C_H, MW, 0, 1, 0));
        rows.push_back(mem(0, C_H, MW, 0, 1, 1));
        rows.push_back(idle(0, C_N, RUN, 0));
        foreach (rows[i]) begin
            cycle(rows[i], got, want);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL mem_wait[%0d] got {%s} want {%s}", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_timeout();
        row_t rows[$];
        obs_t got, want;
        rows.push_back(mem(1, C_H, RUN, 0, 1, 0));
        for (int k = 0; k < 4; k++) rows.push_back(mem(1, C_H, MW, 0, 1, 0));
        rows.push_back(idle(1, C_N, RUN, 1));
        rows.push_back(idle(1, C_N, RUN, 0));
        rows.push_back(mem(1, C_H, RUN, 0, 1, 0));
        for (int k = 0; k < 3; k++) rows.push_back(mem(1, C_H, MW, 0, 1, 0));
        rows.push_back(mem(1, C_H, MW, 0, 1, 1));
        rows.push_back(idle(1, C_N, RUN, 0));
        rows.push_back(idle(1, C_N, RUN, 0));
        foreach (rows[i]) begin
            cycle(rows[i], got, want);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL timeout[%0d] got {%s} want {%s}", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_saturation();
        row_t rows[$];
        obs_t got, want;
        for (int k = 0; k < 2; k++) begin
            rows.push_back(r(1, C_S, RUN, 0, 1, 4, 4, 0, 0, 0, 0, 0, 0, 1));
            rows.push_back(idle(1, C_S, LUS, 0));
            rows.push_back(idle(1, C_S, LUS, 0));
        end
        rows.push_back(idle(1, C_N, RUN, 0));
        foreach (rows[i]) begin
            cycle(rows[i], got, want);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL saturation[%0d] got {%s} want {%s}", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_branch();
        row_t rows[$];
        obs_t got, want;
        rows.push_back(r(0, C_S, RUN, 0, 1, 8, 8, 0, 0, 1, 0, 0, 0, 1));
        rows.push_back(mem(0, C_F, RUN, 1, 0, 0));
        rows.push_back(idle(0, C_N, RUN, 0));
        rows.push_back(mem(0, C_H, RUN, 1, 1, 0));
        rows.push_back(mem(0, C_H, MW, 1, 1, 1));
        rows.push_back(idle(0, C_N, RUN, 0));
        foreach (rows[i]) begin
            cycle(rows[i], got, want);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL branch[%0d] got {%s} want {%s}", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_perf_clr();
        row_t rows[$];
        obs_t got, want;
        rows.push_back(r(0, C_S, RUN, 0, 1, 8, 8, 0, 0, 0, 0, 0, 1, 1));
        rows.push_back(idle(0, C_N, RUN, 0));
        rows.push_back(mem(0, C_F, RUN, 1, 0, 0));
        rows.push_back(r(0, C_F, RUN, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
        rows.push_back(idle(0, C_N, RUN, 0));
        foreach (rows[i]) begin
            cycle(rows[i], got, want);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL perf_clr[%0d] got {%s} want {%s}", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        obs_t got, want;
        rows.push_back(r(0, C_S, RUN, 0, 1, 8, 8, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(r(0, C_S, RUN, 0, 1, 5, 1, 5, 1, 0, 0, 0, 0, 1));
        rows.push_back(idle(0, C_N, RUN, 0));
        rows.push_back(mem(0, C_F, RUN, 1, 0, 0));
        rows.push_back(mem(0, C_F, RUN, 1, 0, 0));
        rows.push_back(idle(0, C_N, RUN, 0));
        foreach (rows[i]) begin
            cycle(rows[i], got, want);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back[%0d] got {%s} want {%s}", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        row_t rows[$];
        obs_t got, want;
        rows.push_back(mem(0, C_H, RUN, 0, 1, 0));
        rows.push_back(mem(0, C_H, MW, 0, 1, 0));
        rows.push_back(r(0, C_R, RUN, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        rows.push_back(idle(0, C_N, RUN, 0));
        rows.push_back(idle(1, C_N, RUN, 0));
        foreach (rows[i]) begin
            cycle(rows[i], got, want);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_mid_wait[%0d] got {%s} want {%s}", i, fmt(got), fmt(want));
            end
        end
    endtask

    initial begin
        stall_m[0] = 0; stall_m[1] = 0; flush_m[0] = 0; flush_m[1] = 0;
        apply(r(0, C_R, RUN, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        test_reset();
        test_lu_single();
        test_no_stall();
        test_lu_multi();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_branch();
        test_perf_clr();
        test_back_to_back();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kim_hazard_ctrl.md
KIM_HAZARD_CTRL -- requirements
Module: kim_hazard_ctrl

Interface
REQ-001 Parameters (name, default, meaning); each SHALL have exactly the stated default:
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard; legal range 1..3.
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before abort; legal range 2..255.
- CNT_W, 16: width of the performance counters.
REQ-002 Ports (name, direction, width, meaning); each SHALL exist exactly as listed:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- id_rs  in  5  Rs field of the instruction in ID (inst[25:21]).
- id_rt  in  5  Rt field of the instruction in ID (inst[20:16]).
- id_uses_rt  in  1  the ID instruction reads Rt as a source.
- ex_memtoreg  in  1  MemtoReg of the instruction in EX (load in EX).
- ex_rt  in  5  destination Rt of the instruction in EX.
- branch_taken  in  1  branch or jump resolved taken in ID this cycle.
- dmem_req  in  1  MEM stage is accessing data memory this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- perf_clr  in  1  synchronous clear of both performance counters.
- pc_we  out  1  PC write enable.
- if_id_we  out  1  IF/ID register write enable.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_ex_bubble  out  1  zero the ID/EX control and data fields; drives the ID/EX stall input.
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- mem_err  out  1  one-cycle pulse marking a memory timeout abort.
- stall_cnt  out  CNT_W  number of cycles with pc_we=0, saturating.
- flush_cnt  out  CNT_W  number of cycles with if_id_flush=1, saturating.
- state  out  2  current FSM state, for debug.

Function
REQ-003 Load-use hazard (lu) SHALL be: ex_memtoreg and ex_rt!=0 and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)).
REQ-004 The FSM SHALL have three states, encoded RUN=0, LU_STALL=1, MEM_WAIT=2; encoding 3 is illegal and SHALL go to RUN on the next clock.
REQ-005 In RUN, the state transitions SHALL follow this priority:
- dmem_req and not dmem_ready -> MEM_WAIT;
- otherwise, if lu is true and LOAD_STALL_CYCLES>1 -> LU_STALL;
- otherwise stay in RUN.
REQ-006 In RUN with lu true and no memory wait, the outputs SHALL be pc_we=0, if_id_we=0, id_ex_bubble=1 in that same cycle (combinational).
REQ-007 LU_STALL SHALL load the counter lu_cnt with LOAD_STALL_CYCLES-1 on entry.
- Each LU_STALL cycle drives pc_we=0, if_id_we=0, id_ex_bubble=1 and decrements lu_cnt.
- When lu_cnt reaches 1, the FSM returns to RUN.
- The total bubble count per hazard SHALL equal LOAD_STALL_CYCLES.
REQ-008 MEM_WAIT SHALL drive pc_we=0, if_id_we=0, pipe_hold=1, id_ex_bubble=0 and if_id_flush=0.
REQ-009 On entry to MEM_WAIT, an 8-bit counter wait_cnt SHALL clear to 0; it increments by 1 in each MEM_WAIT cycle.
REQ-010 MEM_WAIT SHALL exit to RUN when dmem_ready=1; the cycle with dmem_ready=1 still holds the pipeline.
REQ-011 If wait_cnt==MEM_TIMEOUT-1 and dmem_ready=0, the FSM SHALL go to RUN and mem_err SHALL be registered high for exactly the next cycle.
REQ-012 If dmem_ready=1 in the timeout cycle, the access SHALL complete normally and mem_err SHALL stay 0.
REQ-013 if_id_flush SHALL equal 1 only when all of the following hold:
- state is RUN;
- branch_taken=1;
- lu=0;
- no memory wait.
A branch that coincides with a stall SHALL be dropped, because ID re-resolves it after the stall.
REQ-014 With no hazard condition, the outputs SHALL be pc_we=1, if_id_we=1, and all other control outputs 0.
REQ-015 stall_cnt and flush_cnt SHALL increment by 1 per qualifying cycle and saturate at all ones.
- perf_clr=1 clears both counters and has priority over increment.
REQ-016 In LU_STALL, the lu and branch_taken inputs SHALL be ignored.
- A dmem wait arising in LU_STALL SHALL go to MEM_WAIT and abandon the remaining bubbles.

Reset
REQ-017 While rstn=0 the block SHALL hold: state=RUN, lu_cnt=0, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
REQ-018 While rstn=0 the control outputs SHALL be forced to pc_we=0, if_id_we=0, if_id_flush=0, id_ex_bubble=1, pipe_hold=0.
REQ-019 Reset asserted in any state, including in the middle of LU_STALL or MEM_WAIT, SHALL take effect immediately.
- Normal operation resumes on the first clock after rstn deasserts.

Structure
REQ-020 The shared package kim_mips_pkg SHALL hold REG_ADDR_W=5, the FSM state encoding, and the defaults for LOAD_STALL_CYCLES and MEM_TIMEOUT.
REQ-021 The saturating counter SHALL be one sub-module, kim_sat_counter (width parameter, inc input, clr input), instantiated twice.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- ex_memtoreg=1, ex_rt=8, id_rs=8, LOAD_STALL_CYCLES=1 -> one cycle with pc_we=0 and id_ex_bubble=1; stall_cnt=1.
- Same hazard with LOAD_STALL_CYCLES=3 -> exactly 3 bubble cycles, state sequence RUN, LU_STALL, LU_STALL, RUN.
- ex_rt=0 with id_rs=0, or ex_rt=8 with id_rt=8 and id_uses_rt=0 -> no stall.
- dmem_req=1, dmem_ready=0 for 5 cycles then ready -> pipe_hold=1 for 6 cycles, mem_err=0.
- MEM_TIMEOUT=4, dmem_ready held at 0 -> return to RUN after 4 cycles, then a one-cycle mem_err pulse; a ready arriving in the 4th cycle -> no pulse.
- branch_taken together with lu -> no flush; branch_taken alone -> if_id_flush=1 and flush_cnt=1.
- perf_clr together with an increment -> counters read 0.
- rstn pulsed low in the middle of MEM_WAIT -> state=RUN and all counters 0.
